xbar_rr_arbiter: RTL and testbench

Per-output-port round-robin arbiter for the crossbar. It takes one request per input port and issues a registered one-hot grant that stays locked for a whole multi-beat packet. It releases the grant on the packet's last accepted beat. Its `grant` vector is the vector the crossbar's one-hot checker monitors, and it also drives the output-port mux select (`grant_idx`).

---
 rtl/xbar_rr_arbiter.sv | 106 ++++++++++
 tb/tb_xbar_rr_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_rr_arbiter.sv
// Per-output round-robin arbiter: registered one-hot grant, 1-cycle grant latency, locked until last beat.
// Backpressure: out_ready low or a request hole freezes the grant; beat_fire is the combinational handshake.
module xbar_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               beat_fire
);

  localparam int DW = 2 * NUM_REQ;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [IDX_W-1:0]   next_ptr, search_ptr, win_idx;
  logic               pkt_end;
  logic [DW-1:0]      low_mask, dbl_req, dbl_win;
  logic [NUM_REQ-1:0] win_oh;

  assign beat_fire = grant_valid_q & (|(req & grant_q)) & out_ready;
  assign pkt_end   = (state_q == LOCKED) & beat_fire & (|(req_last & grant_q));

  assign next_ptr   = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  assign search_ptr = pkt_end ? next_ptr : ptr_q;

  // Lower copy is masked below the pointer; the upper copy supplies the wrap-around candidates.
  assign low_mask = (DW'(1) << search_ptr) - DW'(1);
  assign dbl_req  = {req, req} & ~low_mask;
  assign dbl_win  = dbl_req & (~dbl_req + DW'(1));
  assign win_oh   = dbl_win[NUM_REQ-1:0] | dbl_win[DW-1:NUM_REQ];

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = win_idx | IDX_W'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d       = win_oh;
          grant_idx_d   = win_idx;
          grant_valid_d = 1'b1;
          state_d       = LOCKED;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          ptr_d = next_ptr;
          if (|req) begin
            grant_d       = win_oh;
            grant_idx_d   = win_idx;
            grant_valid_d = 1'b1;
          end else begin
            grant_d       = '0;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Bench for xbar_rr_arbiter: directed steps then a randomized phase against a scoreboard of expected grants.
// Beat handshake is checked in-cycle; registered grants are checked one cycle after the stimulus that causes them.
module tb_xbar_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  req_last;
  logic          out_ready;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          beat_fire;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  logic         rnd_on = 1'b0;
  int           wait_cnt[N];

  always #5 clk = ~clk;

  xbar_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_last    (req_last),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .beat_fire   (beat_fire)
  );

  function automatic logic [IW-1:0] oh2idx(input logic [N-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) if (oh[k]) r = IW'(k);
    return r;
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] start);
    logic [N-1:0] res;
    bit           found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (int'(start) + k) % N;
      if (!found && r[j]) begin
        res[j] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb: scoreboard empty, observed grant=%0h", tag, grant);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_grant"}, 32'(grant), 32'(e));
      chk({tag, "_idx"},   32'(grant_idx), (e == '0) ? 32'd0 : 32'(oh2idx(e)));
      chk({tag, "_valid"}, 32'(grant_valid), 32'(|e));
    end
  endtask

  // Called at posedge+1: drive this cycle, check beat_fire, expect the grant of the next cycle.
  task automatic drv(input string tag, input logic r, input logic [N-1:0] rq, input logic [N-1:0] lst,
                     input logic rdy, input logic ebf, input logic [N-1:0] enext);
    rst       = r;
    req       = rq;
    req_last  = lst;
    out_ready = rdy;
    #3;
    chk({tag, "_bf"}, 32'(beat_fire), 32'(ebf));
    exp_q.push_back(enext);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  always @(negedge clk) begin
    if (rnd_on) begin
      chk("onehot", 32'((grant & (grant - 4'd1)) == 4'd0), 32'd1);
      chk("valid_or", 32'(grant_valid), 32'(|grant));
      chk("idx_match", 32'(grant_idx), grant_valid ? 32'(oh2idx(grant)) : 32'd0);
      for (int i = 0; i < N; i++) begin
        if (rst || !req[i] || grant[i]) begin
          wait_cnt[i] = 0;
        end else if (beat_fire && (|(req_last & grant))) begin
          wait_cnt[i]++;
          chk("starve", 32'(wait_cnt[i] <= N - 1), 32'd1);
        end
      end
    end
  end

  initial begin
    logic [N-1:0]  rq, lst, ng, m_grant;
    logic [IW-1:0] m_ptr, np;
    logic          r, rdy, ebf;

    rst = 1'b1; req = '0; req_last = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx",   32'(grant_idx), 32'd0);
    chk("rst_bf",    32'(beat_fire), 32'd0);

    drv("rst_hold0", 1, 4'b1111, 4'b1111, 1, 0, 4'b0000);
    drv("rst_hold1", 1, 4'b1111, 4'b1111, 1, 0, 4'b0000);
    drv("release",   0, 4'b1111, 4'b1111, 1, 0, 4'b0001);

    drv("rot0", 0, 4'b1111, 4'b1111, 1, 1, 4'b0010);
    drv("rot1", 0, 4'b1111, 4'b1111, 1, 1, 4'b0100);
    drv("rot2", 0, 4'b1111, 4'b1111, 1, 1, 4'b1000);
    drv("rot3", 0, 4'b1111, 4'b1111, 1, 1, 4'b0001);

    drv("lock_pre", 0, 4'b0111, 4'b0001, 1, 1, 4'b0010);
    drv("lock_b1",  0, 4'b0110, 4'b0000, 1, 1, 4'b0010);
    drv("lock_b2",  0, 4'b0110, 4'b0000, 1, 1, 4'b0010);
    drv("lock_b3",  0, 4'b0110, 4'b0010, 1, 1, 4'b0100);

    drv("to_in0",   0, 4'b0101, 4'b0100, 1, 1, 4'b0001);
    drv("stall_b1", 0, 4'b0001, 4'b0000, 1, 1, 4'b0001);
    drv("hole1",    0, 4'b0000, 4'b0000, 1, 0, 4'b0001);
    drv("hole2",    0, 4'b0110, 4'b0110, 1, 0, 4'b0001);
    drv("rdy_low",  0, 4'b0001, 4'b0001, 0, 0, 4'b0001);
    chk("ptr_hold", 32'(dut.ptr_q), 32'd3);
    drv("stall_end", 0, 4'b0001, 4'b0001, 1, 1, 4'b0001);
    chk("ptr_adv", 32'(dut.ptr_q), 32'd1);

    drv("to_in3", 0, 4'b1001, 4'b0001, 1, 1, 4'b1000);
    drv("lone0",  0, 4'b1000, 4'b1000, 1, 1, 4'b1000);
    chk("ptr_wrap", 32'(dut.ptr_q), 32'd0);
    drv("lone1",  0, 4'b1000, 4'b1000, 1, 1, 4'b1000);
    drv("lone2",  0, 4'b1000, 4'b1000, 1, 1, 4'b1000);

    drv("idle_rst",  1, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    drv("idle0",     0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    drv("idle1",     0, 4'b0000, 4'b0000, 1, 0, 4'b0000);
    drv("idle_wake", 0, 4'b0100, 4'b0100, 1, 0, 4'b0100);

    m_grant = 4'b0100;
    m_ptr   = '0;
    rnd_on  = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        rq[k]  = ($urandom_range(0, 3) != 0);
        lst[k] = ($urandom_range(0, 2) == 0);
      end
      ebf = (m_grant != '0) && (|(rq & m_grant)) && rdy;
      np  = m_ptr;
      if (r) begin
        ng = '0;
        np = '0;
      end else if (m_grant == '0) begin
        ng = (|rq) ? rr_pick(rq, m_ptr) : '0;
      end else if (ebf && (|(lst & m_grant))) begin
        np = IW'((int'(oh2idx(m_grant)) + 1) % N);
        ng = (|rq) ? rr_pick(rq, np) : '0;
      end else begin
        ng = m_grant;
      end
      drv("rnd", r, rq, lst, rdy, ebf, ng);
      m_grant = ng;
      m_ptr   = np;
    end
    rnd_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
